// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester synchronous-ROM arbiter.
package rom_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID0 = 1'b0;
  localparam req_id_t REQ_ID1 = 1'b1;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selection. ROM_ARB_FIXED_PRIORITY_EN selects fixed priority
// (requester 0 wins ties); otherwise ties go to the requester not granted last.
module rom_arb_pick
  import rom_arb_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
`ifndef ROM_ARB_FIXED_PRIORITY_EN
  input  req_id_t last_grant,
`endif
  output req_id_t winner
);

  always_comb begin
    winner = REQ_ID0;
    if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIORITY_EN
      winner = REQ_ID0;
`else
      winner = (last_grant == REQ_ID0) ? REQ_ID1 : REQ_ID0;
`endif
    end else if (req1) begin
      winner = REQ_ID1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a synchronous ROM: one access per 3 cycles.
// Build macro ROM_ARB_FIXED_PRIORITY_EN switches tie-breaking from round-robin to fixed.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  output logic                  ACK0,
  output logic                  VALID0,
  output logic [DATA_WIDTH-1:0] DATA0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  output logic                  ACK1,
  output logic                  VALID1,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  state_t  state;
  state_t  next_state;
  req_id_t winner;
  req_id_t cur_id;
  logic    accept;
  logic    capture;

`ifndef ROM_ARB_FIXED_PRIORITY_EN
  req_id_t last_grant;
`endif

  rom_arb_pick u_pick (
    .req0      (REQ0),
    .req1      (REQ1),
`ifndef ROM_ARB_FIXED_PRIORITY_EN
    .last_grant(last_grant),
`endif
    .winner    (winner)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (REQ0 || REQ1) next_state = WAIT;
      WAIT:    next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && (REQ0 || REQ1);
    capture = (state == CAPTURE);
  end

  // Stage boundary: acceptance registers ACK/ROM_ADDR, capture registers DATA/VALID.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      VALID0   <= 1'b0;
      VALID1   <= 1'b0;
      DATA0    <= '0;
      DATA1    <= '0;
      ROM_ADDR <= '0;
      cur_id   <= REQ_ID0;
    end else begin
      ACK0   <= accept && (winner == REQ_ID0);
      ACK1   <= accept && (winner == REQ_ID1);
      VALID0 <= capture && (cur_id == REQ_ID0);
      VALID1 <= capture && (cur_id == REQ_ID1);
      if (accept) begin
        cur_id   <= winner;
        ROM_ADDR <= (winner == REQ_ID1) ? ADDR1 : ADDR0;
      end
      if (capture && (cur_id == REQ_ID0)) DATA0 <= ROM_DATA;
      if (capture && (cur_id == REQ_ID1)) DATA1 <= ROM_DATA;
    end
  end

`ifndef ROM_ARB_FIXED_PRIORITY_EN
  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (!RESET_N)    last_grant <= REQ_ID1;
    else if (accept) last_grant <= winner;
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_rom_arbiter;

`ifdef ROM_ARB_FIXED_PRIORITY_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic       ack0, ack1, valid0, valid1;
  logic [7:0] data0, data1, rom_addr;
  logic [7:0] rom_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rom_arbiter dut (
    .CLK(clk), .RESET_N(rst_n),
    .REQ0(req0), .ADDR0(addr0), .ACK0(ack0), .VALID0(valid0), .DATA0(data0),
    .REQ1(req1), .ADDR1(addr1), .ACK1(ack1), .VALID1(valid1), .DATA1(data1),
    .ROM_ADDR(rom_addr), .ROM_DATA(rom_data)
  );

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    logic [7:0] t;
    t = a * 8'd7 + 8'd13;
    if (a == 8'h05) t = 8'hA7;
    return t;
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);

  // Reference model: an accepted access occupies the port for three edges,
  // ACK follows acceptance, VALID and data follow two edges later.
  int         m_busy = 0;
  bit         m_last = 1'b1;
  bit         m_win  = 1'b0;
  logic [7:0] m_addr = '0;
  logic       m_ack0 = 0, m_ack1 = 0, m_v0 = 0, m_v1 = 0;
  logic [7:0] m_d0 = '0, m_d1 = '0, m_raddr = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_last = 1'b1;
      m_ack0 = 0; m_ack1 = 0; m_v0 = 0; m_v1 = 0;
      m_d0 = '0; m_d1 = '0; m_raddr = '0;
    end else begin
      m_ack0 = 0; m_ack1 = 0; m_v0 = 0; m_v1 = 0;
      if (m_busy == 0) begin
        if (req0 || req1) begin
          if (req0 && req1) m_win = FP ? 1'b0 : !m_last;
          else              m_win = req1;
          m_last  = m_win;
          m_addr  = m_win ? addr1 : addr0;
          m_raddr = m_addr;
          if (m_win) m_ack1 = 1; else m_ack0 = 1;
          m_busy = 2;
        end
      end else begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          if (m_win) begin m_d1 = rom_val(m_addr); m_v1 = 1; end
          else       begin m_d0 = rom_val(m_addr); m_v0 = 1; end
        end
      end
    end
  end

  typedef struct {
    logic       rst_n, r0, r1;
    logic [7:0] a0, a1;
    logic       ack0, ack1, v0, v1;
    logic [7:0] d0, d1, raddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs, input logic r0, input logic r1,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic k0, input logic k1, input logic v0, input logic v1,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] ra);
    vec_t v;
    v.rst_n = rs; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.ack0 = k0; v.ack1 = k1; v.v0 = v0; v.v1 = v1;
    v.d0 = d0; v.d1 = d1; v.raddr = ra;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [43:0] got, want;
  logic [7:0]  d0c, d1c;
  bit          g;

  initial begin
    // Single request, requester 0.
    add(0,0,0,8'h00,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00);
    add(1,1,0,8'h05,8'h00, 1,0,0,0, 8'h00,8'h00,8'h05);
    add(1,0,0,8'h05,8'h00, 0,0,0,0, 8'h00,8'h00,8'h05);
    add(1,0,0,8'h05,8'h00, 0,0,1,0, 8'hA7,8'h00,8'h05);
    add(1,0,0,8'h00,8'h00, 0,0,0,0, 8'hA7,8'h00,8'h05);
    // Continuous tie from reset.
    add(0,0,0,8'h00,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00);
    d0c = 8'h00; d1c = 8'h00;
    for (int k = 0; k < 4; k++) begin
      g = FP ? 1'b0 : k[0];
      add(1,1,1,8'h10,8'h20, !g,g,0,0, d0c,d1c, g ? 8'h20 : 8'h10);
      add(1,1,1,8'h10,8'h20, 0,0,0,0,  d0c,d1c, g ? 8'h20 : 8'h10);
      if (g) d1c = 8'hED; else d0c = 8'h7D;
      add(1,1,1,8'h10,8'h20, 0,0,!g,g, d0c,d1c, g ? 8'h20 : 8'h10);
    end
    // Address wrap on requester 0; DATA1 must not move.
    add(1,1,0,8'hFF,8'h20, 1,0,0,0, d0c,  d1c,8'hFF);
    add(1,0,0,8'hFF,8'h20, 0,0,0,0, d0c,  d1c,8'hFF);
    add(1,0,0,8'hFF,8'h20, 0,0,1,0, 8'h06,d1c,8'hFF);
    add(1,1,0,8'h00,8'h20, 1,0,0,0, 8'h06,d1c,8'h00);
    add(1,0,0,8'h00,8'h20, 0,0,0,0, 8'h06,d1c,8'h00);
    add(1,0,0,8'h00,8'h20, 0,0,1,0, 8'h0D,d1c,8'h00);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; req0 = tbl[i].r0; req1 = tbl[i].r1;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1;
      step();
      got  = {ack0, ack1, valid0, valid1, data0, data1, rom_addr, 8'h00};
      want = {tbl[i].ack0, tbl[i].ack1, tbl[i].v0, tbl[i].v1,
              tbl[i].d0, tbl[i].d1, tbl[i].raddr, 8'h00};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL table row %0d: got %h expected %h", i, got, want);
      end
    end

    // Withdrawal: REQ1 pulses during WAIT of a requester 0 access.
    rst_n = 0; req0 = 0; req1 = 0; step();
    rst_n = 1; req0 = 1; addr0 = 8'h05; step();
    chk("wd_ack0", ack0, 1);
    req0 = 0; req1 = 1; addr1 = 8'h20; step();
    chk("wd_ack1_wait", ack1, 0);
    req1 = 0; step();
    chk("wd_valid0", {valid0, valid1, data0}, {2'b10, 8'hA7});
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wd_no_ack1_valid1", {ack1, valid1, data1}, 10'h000);
    end

    // Reset in WAIT abandons the access.
    req0 = 1; addr0 = 8'h10; step();
    chk("rst_ack0", {ack0, rom_addr}, {1'b1, 8'h10});
    req0 = 0; rst_n = 0; step();
    chk("rst_outputs", {ack0, ack1, valid0, valid1, data0, data1, rom_addr}, 28'h0);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_valid", {valid0, valid1}, 2'b00);
    end
    req1 = 1; addr1 = 8'hFF; step();
    chk("rst_ack1", {ack1, rom_addr}, {1'b1, 8'hFF});
    req1 = 0; step(); step();
    chk("rst_valid1", {valid1, data1}, {1'b1, 8'h06});

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      req0  = $urandom_range(0, 2) != 0;
      req1  = $urandom_range(0, 2) != 0;
      addr0 = 8'($urandom);
      addr1 = 8'($urandom);
      step();
      got  = {ack0, ack1, valid0, valid1, data0, data1, rom_addr, 8'h00};
      want = {m_ack0, m_ack1, m_v0, m_v1, m_d0, m_d1, m_raddr, 8'h00};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h expected %h", n, got, want);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
